// File: rtl/line_scheduler.sv
// line_scheduler: per-frame line sequencer (read DMA -> filter kick -> write DMA), one line in flight.
// Optional watchdog compiled in by defining SCHED_TIMEOUT_EN.
module line_scheduler #(
  parameter int unsigned WIDTH       = 1600,
  parameter int unsigned HEIGHT      = 900,
  parameter int unsigned LINE_BYTES  = WIDTH * 4,
  parameter logic [31:0] RD_BASE     = 32'h0000_0000,
  parameter logic [31:0] WR_BASE     = 32'h0100_0000,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_done,
  output logic        kick_line,
  output logic [11:0] kick_posy,
  input  logic        proc_done,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  input  logic        wr_ack,
  input  logic        wr_done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_KICK, S_PROC_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
  } state_t;

  localparam logic [11:0] LAST_LINE = 12'(HEIGHT - 1);
  localparam logic [31:0] STRIDE    = 32'(LINE_BYTES);

  if (HEIGHT < 1 || HEIGHT > 4095 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 2097151) begin : g_bad_param
    $error("line_scheduler: HEIGHT or TIMEOUT_CYC out of range");
  end

  state_t state_r;
  logic   proc_prev_r;
  logic   proc_edge_r;
  logic   timeout_s;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [20:0] WD_LAST = 21'(TIMEOUT_CYC - 1);

  logic [20:0] wd_cnt_r;
  logic        error_r;
  logic        wait_hold_s;

  assign wait_hold_s = (state_r == S_RD_WAIT   && !rd_done)     ||
                       (state_r == S_PROC_WAIT && !proc_edge_r) ||
                       (state_r == S_WR_WAIT   && !wr_done);
  assign timeout_s   = wait_hold_s && (wd_cnt_r == WD_LAST);
  assign error       = error_r;

  // Watchdog: counts stalled wait-state cycles, zero in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= 21'd0;
    end else if (wait_hold_s && !timeout_s) begin
      wd_cnt_r <= wd_cnt_r + 21'd1;
    end else begin
      wd_cnt_r <= 21'd0;
    end
  end

  // Sticky error flag, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_r <= 1'b0;
    end else if (timeout_s) begin
      error_r <= 1'b1;
    end else if (state_r == S_IDLE && start) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_r;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign error     = 1'b0;
`endif

  // PROC_DONE rising-edge register; edges only count while waiting for the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_prev_r <= 1'b0;
      proc_edge_r <= 1'b0;
    end else begin
      proc_prev_r <= proc_done;
      proc_edge_r <= (state_r == S_PROC_WAIT) && proc_done && !proc_prev_r;
    end
  end

  // Line sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rd_req     <= 1'b0;
      rd_addr    <= RD_BASE;
      kick_line  <= 1'b0;
      kick_posy  <= 12'd0;
      wr_req     <= 1'b0;
      wr_addr    <= WR_BASE;
    end else if (timeout_s) begin
      state_r    <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rd_req     <= 1'b0;
      kick_line  <= 1'b0;
      wr_req     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          frame_done <= 1'b0;
          kick_line  <= 1'b0;
          wr_req     <= 1'b0;
          if (start) begin
            state_r   <= S_RD_REQ;
            busy      <= 1'b1;
            rd_req    <= 1'b1;
            kick_posy <= 12'd0;
            rd_addr   <= RD_BASE;
            wr_addr   <= WR_BASE;
          end else begin
            busy   <= 1'b0;
            rd_req <= 1'b0;
          end
        end
        S_RD_REQ: begin
          if (rd_ack) begin
            rd_req  <= 1'b0;
            state_r <= S_RD_WAIT;
          end else begin
            rd_req <= 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (rd_done) begin
            kick_line <= 1'b1;
            state_r   <= S_KICK;
          end else begin
            kick_line <= 1'b0;
          end
        end
        S_KICK: begin
          kick_line <= 1'b0;
          state_r   <= S_PROC_WAIT;
        end
        S_PROC_WAIT: begin
          if (proc_edge_r) begin
            wr_req  <= 1'b1;
            state_r <= S_WR_REQ;
          end else begin
            wr_req <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (wr_ack) begin
            wr_req  <= 1'b0;
            state_r <= S_WR_WAIT;
          end else begin
            wr_req <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (wr_done && kick_posy == LAST_LINE) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state_r    <= S_DONE;
          end else if (wr_done) begin
            kick_posy <= kick_posy + 12'd1;
            rd_addr   <= rd_addr + STRIDE;
            wr_addr   <= wr_addr + STRIDE;
            rd_req    <= 1'b1;
            state_r   <= S_RD_REQ;
          end else begin
            state_r <= S_WR_WAIT;
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r    <= S_IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          rd_req     <= 1'b0;
          kick_line  <= 1'b0;
          wr_req     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_scheduler.sv
// Self-checking bench for line_scheduler: table-driven line vectors with an expected-value queue,
// plus hand-written reset, watchdog and address wrap-around sequences.
module tb_line_scheduler;

  localparam logic [31:0] RD_BASE = 32'h0000_0000;
  localparam logic [31:0] WR_BASE = 32'h0100_0000;

  typedef struct {
    int          ack_dly;
    int          done_dly;
    int          proc_dly;
    int          proc_len;
    bit          poke;
    logic [31:0] rd_a;
    logic [31:0] wr_a;
    logic [11:0] posy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, rd_ack = 1'b0, rd_done = 1'b0, proc_done = 1'b0, wr_ack = 1'b0, wr_done = 1'b0;
  logic busy, frame_done, rd_req, kick_line, wr_req, error;
  logic [31:0] rd_addr, wr_addr;
  logic [11:0] kick_posy;

  logic w_start = 1'b0, w_rd_ack = 1'b0, w_rd_done = 1'b0, w_proc = 1'b0, w_wr_ack = 1'b0, w_wr_done = 1'b0;
  logic w_busy, w_frame_done, w_rd_req, w_kick_line, w_wr_req, w_error;
  logic [31:0] w_rd_addr, w_wr_addr;
  logic [11:0] w_kick_posy;

  int n_vec = 0;
  int n_err = 0;
  int kick_cnt = 0, wreq_cnt = 0, fd_cnt = 0;
  logic wr_req_q = 1'b0;
  vec_t vecs [4];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  line_scheduler #(
    .WIDTH(1600), .HEIGHT(4), .LINE_BYTES(6400),
    .RD_BASE(RD_BASE), .WR_BASE(WR_BASE), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
    .kick_line(kick_line), .kick_posy(kick_posy), .proc_done(proc_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_done(wr_done), .error(error)
  );

  line_scheduler #(
    .WIDTH(1600), .HEIGHT(2), .LINE_BYTES(6400),
    .RD_BASE(32'hFFFF_F000), .WR_BASE(WR_BASE), .TIMEOUT_CYC(100)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .busy(w_busy), .frame_done(w_frame_done),
    .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_ack(w_rd_ack), .rd_done(w_rd_done),
    .kick_line(w_kick_line), .kick_posy(w_kick_posy), .proc_done(w_proc),
    .wr_req(w_wr_req), .wr_addr(w_wr_addr), .wr_ack(w_wr_ack), .wr_done(w_wr_done), .error(w_error)
  );

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (kick_line) kick_cnt++;
    if (frame_done) fd_cnt++;
    if (wr_req && !wr_req_q) wreq_cnt++;
    wr_req_q = wr_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rd(input string name);
    int k;
    k = 0;
    while (rd_req !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({name, " rd_req seen"}, {31'd0, rd_req}, 32'd1);
  endtask

  task automatic serve_line(input bit stop_wr);
    vec_t e;
    bit   stable;
    e = exp_q.pop_front();
    wait_rd("line");
    check("rd_addr", rd_addr, e.rd_a);
    check("busy in frame", {31'd0, busy}, 32'd1);
    stable = 1'b1;
    for (int k = 0; k < e.ack_dly; k++) begin
      tick();
      if (rd_req !== 1'b1 || rd_addr !== e.rd_a) stable = 1'b0;
    end
    if (e.ack_dly > 0) check("rd_req stable", {31'd0, stable}, 32'd1);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    check("rd_req drop", {31'd0, rd_req}, 32'd0);
    if (e.poke) begin
      proc_done = 1'b1; start = 1'b1; tick(); proc_done = 1'b0; start = 1'b0;
    end
    repeat (e.done_dly) tick();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    check("kick_line", {31'd0, kick_line}, 32'd1);
    check("kick_posy", {20'd0, kick_posy}, {20'd0, e.posy});
    tick();
    check("kick one cycle", {31'd0, kick_line}, 32'd0);
    repeat (e.proc_dly) tick();
    proc_done = 1'b1; tick();
    if (e.proc_len == 1) proc_done = 1'b0;
    check("proc edge latency", {31'd0, wr_req}, 32'd0);
    tick();
    if (e.proc_len == 2) proc_done = 1'b0;
    check("wr_req", {31'd0, wr_req}, 32'd1);
    check("wr_addr", wr_addr, e.wr_a);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0; proc_done = 1'b0;
    check("wr_req drop", {31'd0, wr_req}, 32'd0);
    if (!stop_wr) begin
      repeat (e.done_dly) tick();
      wr_done = 1'b1; tick(); wr_done = 1'b0;
    end
  endtask

  task automatic w_line(input logic [31:0] exp_rd, input logic [31:0] exp_wr, input bit last);
    check("wrap rd_req", {31'd0, w_rd_req}, 32'd1);
    check("wrap rd_addr", w_rd_addr, exp_rd);
    w_rd_ack = 1'b1; tick(); w_rd_ack = 1'b0;
    w_rd_done = 1'b1; tick(); w_rd_done = 1'b0;
    tick();
    w_proc = 1'b1; tick(); w_proc = 1'b0; tick();
    check("wrap wr_req", {31'd0, w_wr_req}, 32'd1);
    check("wrap wr_addr", w_wr_addr, exp_wr);
    w_wr_ack = 1'b1; tick(); w_wr_ack = 1'b0;
    w_wr_done = 1'b1; tick(); w_wr_done = 1'b0;
    if (last) check("wrap frame_done", {31'd0, w_frame_done}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " busy"}, {31'd0, busy}, 32'd0);
    check({name, " frame_done"}, {31'd0, frame_done}, 32'd0);
    check({name, " rd_req"}, {31'd0, rd_req}, 32'd0);
    check({name, " kick_line"}, {31'd0, kick_line}, 32'd0);
    check({name, " wr_req"}, {31'd0, wr_req}, 32'd0);
    check({name, " error"}, {31'd0, error}, 32'd0);
    check({name, " kick_posy"}, {20'd0, kick_posy}, 32'd0);
    check({name, " rd_addr"}, rd_addr, RD_BASE);
    check({name, " wr_addr"}, wr_addr, WR_BASE);
  endtask

  task automatic run_frame(input string name);
    int k0, w0, f0;
    k0 = kick_cnt; w0 = wreq_cnt; f0 = fd_cnt;
    start = 1'b1; tick(); start = 1'b0;
    check({name, " start busy"}, {31'd0, busy}, 32'd1);
    check({name, " start rd_req"}, {31'd0, rd_req}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(vecs[i]);
    for (int i = 0; i < 4; i++) serve_line(1'b0);
    check({name, " frame_done"}, {31'd0, frame_done}, 32'd1);
    check({name, " busy at done"}, {31'd0, busy}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check({name, " frame_done pulse"}, {31'd0, frame_done}, 32'd0);
    tick();
    check({name, " start in done ignored"}, {31'd0, busy}, 32'd0);
    check({name, " no rd_req after done"}, {31'd0, rd_req}, 32'd0);
    check({name, " kick count"}, 32'(kick_cnt - k0), 32'd4);
    check({name, " wr_req count"}, 32'(wreq_cnt - w0), 32'd4);
    check({name, " frame_done count"}, 32'(fd_cnt - f0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int f0;
    vecs[0] = '{0, 10, 50, 1, 1'b0, 32'h0000_0000, 32'h0100_0000, 12'd0};
    vecs[1] = '{7, 10, 50, 1, 1'b1, 32'h0000_1900, 32'h0100_1900, 12'd1};
    vecs[2] = '{0, 10, 50, 3, 1'b0, 32'h0000_3200, 32'h0100_3200, 12'd2};
    vecs[3] = '{2, 10, 50, 2, 1'b0, 32'h0000_4B00, 32'h0100_4B00, 12'd3};

    tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_frame("frame1");

    // Abandon a frame by reset while line 2 waits for WR_DONE.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(vecs[i]);
    serve_line(1'b0);
    serve_line(1'b0);
    serve_line(1'b1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid-frame reset");
    tick();
    rst_n = 1'b1;
    tick();
    run_frame("frame2");

    // Stall RD_DONE forever.
    start = 1'b1; tick(); start = 1'b0;
    wait_rd("wd");
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    f0 = fd_cnt;
    repeat (99) tick();
`ifdef SCHED_TIMEOUT_EN
    check("wd error early", {31'd0, error}, 32'd0);
    check("wd busy early", {31'd0, busy}, 32'd1);
    tick();
    check("wd error", {31'd0, error}, 32'd1);
    check("wd busy", {31'd0, busy}, 32'd0);
    check("wd rd_req", {31'd0, rd_req}, 32'd0);
    repeat (3) tick();
    check("wd error sticky", {31'd0, error}, 32'd1);
    check("wd no frame_done", 32'(fd_cnt - f0), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("wd error cleared by start", {31'd0, error}, 32'd0);
    check("wd restart busy", {31'd0, busy}, 32'd1);
`else
    repeat (50) tick();
    check("no wd busy", {31'd0, busy}, 32'd1);
    check("no wd error", {31'd0, error}, 32'd0);
    check("no wd frame_done", 32'(fd_cnt - f0), 32'd0);
`endif
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Address wrap-around on the HEIGHT=2 instance.
    w_start = 1'b1; tick(); w_start = 1'b0;
    w_line(32'hFFFF_F000, 32'h0100_0000, 1'b0);
    w_line(32'h0000_0900, 32'h0100_1900, 1'b1);
    tick();
    check("wrap busy end", {31'd0, w_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_scheduler.md
Name: line_scheduler

Overview:
- Per-frame line sequencer in front of processing_wrapper.
- For each line 0..HEIGHT-1, in order: issue a line-read request to the frame-buffer read DMA, kick the filter once the line is buffered, wait for the filter to finish the line, then issue the write-back request to the write DMA.
- One line in flight at a time. Raises FRAME_DONE after the last line is written.

Parameters:
- WIDTH, 1600: pixels per line; informational only, used to derive LINE_BYTES.
- HEIGHT, 900: lines per frame; valid range 1..4095.
- LINE_BYTES, 6400: byte stride between lines (WIDTH*4, 32-bit pixels).
- RD_BASE, 32'h0000_0000: byte address of source frame line 0.
- WR_BASE, 32'h0100_0000: byte address of destination frame line 0.
- TIMEOUT_CYC, 1048576: watchdog limit in cycles; used only with SCHED_TIMEOUT_EN.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- START  in  1  one-cycle pulse that begins a frame; ignored while BUSY=1.
- BUSY  out  1  high from the cycle after an accepted START until FRAME_DONE.
- FRAME_DONE  out  1  one-cycle pulse after the last line's WR_DONE.
- RD_REQ  out  1  read-DMA request; held until acknowledged.
- RD_ADDR  out  32  line source address; stable while RD_REQ=1.
- RD_ACK  in  1  read-DMA accept; transfer occurs on RD_REQ&RD_ACK.
- RD_DONE  in  1  pulse: line fully loaded into the line buffer.
- KICK_LINE  out  1  one-cycle pulse to processing_wrapper READ_LINE_DONE.
- KICK_POSY  out  12  current line index; drives READ_POSY; valid whenever BUSY=1.
- PROC_DONE  in  1  processing_wrapper WRITE_LINE_DONE; a level that may last more than 1 cycle.
- WR_REQ  out  1  write-DMA request; held until acknowledged.
- WR_ADDR  out  32  line destination address; stable while WR_REQ=1.
- WR_ACK  in  1  write-DMA accept.
- WR_DONE  in  1  pulse: line fully written to memory.
- ERROR  out  1  sticky watchdog flag; stays 0 when the feature is compiled out.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, line=0, all outputs 0.
  - Addresses reload to RD_BASE/WR_BASE. The PROC_DONE edge register clears.
  - Reset mid-frame abandons the frame immediately. No DMA handshake completes.
- FSM states: IDLE, RD_REQ, RD_WAIT, KICK, PROC_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: on START go to RD_REQ. line=0, RD_ADDR=RD_BASE, WR_ADDR=WR_BASE, BUSY=1 next cycle.
- RD_REQ: RD_REQ=1. On RD_ACK go to RD_WAIT and drop RD_REQ the next cycle. RD_ACK may arrive in the first RD_REQ cycle.
- RD_WAIT: on RD_DONE go to KICK. RD_DONE is ignored in every other state.
- KICK: KICK_LINE=1 for exactly one cycle, KICK_POSY=line. Next state PROC_WAIT.
- PROC_WAIT: wait for a rising edge of PROC_DONE (registered previous value 0, current 1), then go to WR_REQ.
  - A level already high on entry is not an edge.
  - Edges seen outside PROC_WAIT are discarded.
- WR_REQ and WR_WAIT: same rules as the read side, using WR_ACK and WR_DONE.
- WR_WAIT on WR_DONE:
  - If line==HEIGHT-1, go to DONE.
  - Otherwise line+1, RD_ADDR+=LINE_BYTES, WR_ADDR+=LINE_BYTES, go to RD_REQ.
- DONE: FRAME_DONE=1 for one cycle, BUSY=0, go to IDLE.
- Address arithmetic: 32-bit accumulators with modulo-2^32 wrap. No multiplier.
- Latency:
  - START to first RD_REQ: 1 cycle.
  - RD_DONE to KICK_LINE: 1 cycle.
  - PROC_DONE edge to WR_REQ: 2 cycles (edge register plus state change).
  - Last WR_DONE to FRAME_DONE: 1 cycle.
- START in the FRAME_DONE cycle is ignored. START is accepted from IDLE only.
- HEIGHT=1: a single line, then DONE.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- With the macro defined:
  - A 21-bit counter clears on every state change and increments in RD_WAIT, PROC_WAIT and WR_WAIT.
  - On reaching TIMEOUT_CYC: ERROR<=1, all requests drop, go to IDLE, BUSY=0, no FRAME_DONE.
  - ERROR clears only on reset or on the next accepted START.
- Without the macro: no counter, ERROR tied 0, waits are unbounded.

Test Plan:
- Frame sweep:
  - Stimulus: HEIGHT=4, LINE_BYTES=6400, DMA acks in 0 cycles, dones after 10 cycles, PROC_DONE high 1 cycle 50 cycles after each kick.
  - Required: RD_ADDR 0x0, 0x1900, 0x3200, 0x4B00; KICK_POSY 0..3; exactly 4 KICK_LINE and 4 WR_REQ; one FRAME_DONE; BUSY then 0.
- Delayed ack:
  - Stimulus: RD_ACK held low 7 cycles.
  - Required: RD_REQ and RD_ADDR stable all 7 cycles; RD_REQ drops the cycle after the ack.
- PROC_DONE edge:
  - Stimulus: PROC_DONE held high 3 cycles.
  - Required: exactly one WR_REQ sequence. A PROC_DONE pulse during RD_WAIT produces no write.
- Busy and reset:
  - Stimulus: START while BUSY; then RST_N low during WR_WAIT of line 2.
  - Required: START ignored; after reset all outputs 0; a new START begins at line 0 with RD_ADDR=RD_BASE.
- Watchdog:
  - Stimulus: SCHED_TIMEOUT_EN with TIMEOUT_CYC=100, RD_DONE never arrives.
  - Required: ERROR=1 at 100 cycles in RD_WAIT, BUSY=0, no FRAME_DONE. Without the macro, BUSY stays 1 and ERROR=0.
- Wrap-around:
  - Stimulus: RD_BASE=32'hFFFF_F000, LINE_BYTES=6400, HEIGHT=2.
  - Required: second RD_ADDR=32'h0000_0900.
